sparc_ifu_fetch_arb: RTL and testbench

Four-thread fetch-port arbiter for the IFU. It shares the single I-cache fetch port among threads 0-3 using least-recently-granted round-robin. Each grant is held until the fetch port acknowledges completion, and a hold-time watchdog flags a stuck port. It sits between the per-thread fetch request logic and the I-cache access pipeline.

---
 rtl/sparc_ifu_fetch_arb.sv | 144 ++++++++++++++
 tb/tb_sparc_ifu_fetch_arb.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sparc_ifu_fetch_arb.sv
// Four-thread I-cache fetch-port arbiter: least-recently-granted round-robin,
// grant held until ack or kill, with a sticky hold-time watchdog.
module sparc_ifu_fetch_arb #(
   parameter int unsigned MAX_HOLD = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] req_vec,
   input  logic [3:0] kill_vec,
   input  logic       ack,
   input  logic       err_clr,
   input  logic       rst_tri_enable,
   output logic [3:0] grant_vec,
   output logic       gnt_vld,
   output logic [1:0] last_gnt,
   output logic       timeout_err
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] grant_q, grant_d;
   logic [3:0] park_q, park_d;
   logic [7:0] hold_cnt_q, hold_cnt_d;
   logic       timeout_err_q, timeout_err_d;
   logic [3:0] elig_s;
   logic [3:0] next_s;

   function automatic logic [1:0] enc_oh(input logic [3:0] oh);
      logic [1:0] idx;
      case (oh)
         4'b0001: idx = 2'd0;
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

   // Walk from lowest priority (the park slot itself) to highest so the
   // thread right after park overrides everything else.
   function automatic logic [3:0] pick(input logic [3:0] elig, input logic [1:0] park_idx);
      logic [3:0] gnt;
      logic [1:0] idx;
      gnt = 4'b0000;
      for (int i = 4; i >= 1; i--) begin
         idx = park_idx + 2'(i);
         if (elig[idx]) begin
            gnt = 4'b0001 << idx;
         end else begin
            gnt = gnt;
         end
      end
      return gnt;
   endfunction

   // Next-state, grant, park, watchdog computation.
   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      park_d        = park_q;
      hold_cnt_d    = hold_cnt_q;
      timeout_err_d = timeout_err_q;
      elig_s        = req_vec & ~kill_vec;
      next_s        = 4'b0000;

      case (state_q)
         IDLE: begin
            next_s = pick(elig_s, enc_oh(park_q));
            if (next_s != 4'b0000) begin
               grant_d    = next_s;
               park_d     = next_s;
               hold_cnt_d = 8'd1;
               state_d    = BUSY;
            end else begin
               hold_cnt_d = 8'd0;
            end
         end
         BUSY: begin
            if (ack) begin
               next_s = pick(elig_s & ~grant_q, enc_oh(park_q));
               if (next_s != 4'b0000) begin
                  grant_d    = next_s;
                  park_d     = next_s;
                  hold_cnt_d = 8'd1;
               end else begin
                  grant_d    = 4'b0000;
                  hold_cnt_d = 8'd0;
                  state_d    = IDLE;
               end
            end else if ((kill_vec & grant_q) != 4'b0000) begin
               grant_d    = 4'b0000;
               hold_cnt_d = 8'd0;
               state_d    = IDLE;
            end else if (hold_cnt_q != 8'hFF) begin
               hold_cnt_d = hold_cnt_q + 8'd1;
            end else begin
               hold_cnt_d = hold_cnt_q;
            end
         end
         default: begin
            state_d    = IDLE;
            grant_d    = 4'b0000;
            hold_cnt_d = 8'd0;
         end
      endcase

      // Setting the flag takes precedence over a simultaneous clear.
      if ((state_q == BUSY) && (hold_cnt_q == 8'(MAX_HOLD)) && !ack) begin
         timeout_err_d = 1'b1;
      end else if (err_clr) begin
         timeout_err_d = 1'b0;
      end else begin
         timeout_err_d = timeout_err_q;
      end
   end

   // State registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         grant_q       <= 4'b0000;
         park_q        <= 4'b0001;
         hold_cnt_q    <= 8'd0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         park_q        <= park_d;
         hold_cnt_q    <= hold_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign grant_vec   = rst_tri_enable ? 4'b0001 : grant_q;
   assign gnt_vld     = rst_tri_enable ? 1'b0 : (|grant_q);
   assign last_gnt    = enc_oh(park_q);
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_sparc_ifu_fetch_arb.sv
// Directed scoreboard bench for sparc_ifu_fetch_arb (MAX_HOLD=4).
module tb_sparc_ifu_fetch_arb;

   logic       clk;
   logic       reset;
   logic [3:0] req_vec;
   logic [3:0] kill_vec;
   logic       ack;
   logic       err_clr;
   logic       rst_tri_enable;
   logic [3:0] grant_vec;
   logic       gnt_vld;
   logic [1:0] last_gnt;
   logic       timeout_err;

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      string      tag;
      logic [3:0] g;
      logic       vld;
      logic [1:0] last;
      logic       to;
   } exp_t;

   exp_t sb[$];

   sparc_ifu_fetch_arb #(.MAX_HOLD(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .req_vec        (req_vec),
      .kill_vec       (kill_vec),
      .ack            (ack),
      .err_clr        (err_clr),
      .rst_tri_enable (rst_tri_enable),
      .grant_vec      (grant_vec),
      .gnt_vld        (gnt_vld),
      .last_gnt       (last_gnt),
      .timeout_err    (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic cmp(input string tag, input logic [3:0] act, input logic [3:0] exp);
      n_chk++;
      assert (act === exp) n_pass++;
      else $error("FAIL %s: observed %b expected %b", tag, act, exp);
   endtask

   // Expected outputs given the architectural grant and the test override.
   task automatic push(input string tag, input logic [3:0] g, input logic [1:0] last, input logic to);
      exp_t e;
      e.tag  = tag;
      e.g    = rst_tri_enable ? 4'b0001 : g;
      e.vld  = rst_tri_enable ? 1'b0 : (g != 4'b0000);
      e.last = last;
      e.to   = to;
      sb.push_back(e);
   endtask

   task automatic check_pop();
      exp_t e;
      n_chk++;
      assert (sb.size() != 0) n_pass++;
      else $error("FAIL scoreboard: observed empty queue expected entry");
      if (sb.size() != 0) begin
         e = sb.pop_front();
         cmp({e.tag, "_gnt"}, grant_vec, e.g);
         cmp({e.tag, "_vld"}, {3'b000, gnt_vld}, {3'b000, e.vld});
         cmp({e.tag, "_last"}, {2'b00, last_gnt}, {2'b00, e.last});
         cmp({e.tag, "_to"}, {3'b000, timeout_err}, {3'b000, e.to});
         n_chk++;
         assert ($onehot0(grant_vec)) n_pass++;
         else $error("FAIL %s_onehot: observed %b expected at most one bit", e.tag, grant_vec);
      end
   endtask

   task automatic cyc(input string tag, input logic [3:0] req, input logic [3:0] kill,
                      input logic a, input logic clr,
                      input logic [3:0] g, input logic [1:0] last, input logic to);
      req_vec  = req;
      kill_vec = kill;
      ack      = a;
      err_clr  = clr;
      push(tag, g, last, to);
      @(posedge clk);
      #1;
      check_pop();
   endtask

   initial begin
      reset          = 1'b1;
      req_vec        = 4'b0000;
      kill_vec       = 4'b0000;
      ack            = 1'b0;
      err_clr        = 1'b0;
      rst_tri_enable = 1'b0;
      #12;
      push("reset", 4'b0000, 2'd0, 1'b0);
      check_pop();
      @(negedge clk);
      reset = 1'b0;

      // Round robin with all threads requesting, ack each cycle.
      cyc("rr0", 4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0010, 2'd1, 1'b0);
      cyc("rr1", 4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b0);
      cyc("rr2", 4'b1111, 4'b0000, 1'b1, 1'b0, 4'b1000, 2'd3, 1'b0);
      cyc("rr3", 4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b0);
      cyc("rr4", 4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b0);
      cyc("rr_end", 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd1, 1'b0);

      // Idle cycles must not rotate priority.
      cyc("park_g2", 4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b0);
      cyc("park_ack", 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd2, 1'b0);
      for (int i = 0; i < 5; i++) begin
         cyc("park_idle", 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b0);
      end
      cyc("park_g0", 4'b0101, 4'b0000, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b0);
      cyc("park_rel", 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0);

      // Sole requester: ack returns to idle, then re-grant.
      cyc("solo_g1", 4'b0010, 4'b0000, 1'b0, 1'b0, 4'b0010, 2'd1, 1'b0);
      cyc("solo_ack", 4'b0010, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd1, 1'b0);
      cyc("solo_reg", 4'b0010, 4'b0000, 1'b0, 1'b0, 4'b0010, 2'd1, 1'b0);
      cyc("solo_rel", 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd1, 1'b0);

      // Kill of the granted thread counts as its turn.
      cyc("kill_g3", 4'b1000, 4'b0000, 1'b0, 1'b0, 4'b1000, 2'd3, 1'b0);
      cyc("kill_hit", 4'b1001, 4'b1000, 1'b0, 1'b0, 4'b0000, 2'd3, 1'b0);
      cyc("kill_g0", 4'b1001, 4'b0000, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b0);
      cyc("kill_rel", 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0);

      // Watchdog with MAX_HOLD=4; requester drops but grant is held.
      cyc("wd_g2", 4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b0);
      cyc("wd_h2", 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b0);
      cyc("wd_h3", 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b0);
      cyc("wd_h4", 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b0);
      cyc("wd_set", 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1);
      cyc("wd_stay", 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1);
      cyc("wd_clr", 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b0);
      cyc("wd_rel", 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd2, 1'b0);

      // Test override during a grant; counter keeps running underneath.
      cyc("tri_g2", 4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b0);
      rst_tri_enable = 1'b1;
      push("tri_on", 4'b0100, 2'd2, 1'b0);
      #1;
      check_pop();
      cyc("tri_h2", 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b0);
      cyc("tri_h3", 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b0);
      rst_tri_enable = 1'b0;
      push("tri_off", 4'b0100, 2'd2, 1'b0);
      #1;
      check_pop();
      cyc("tri_h4", 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b0);
      cyc("tri_setwin", 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1);
      cyc("tri_rel", 4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0000, 2'd2, 1'b0);

      // Asynchronous reset mid-grant drops the grant immediately.
      cyc("ar_g3", 4'b1000, 4'b0000, 1'b0, 1'b0, 4'b1000, 2'd3, 1'b0);
      #2;
      reset = 1'b1;
      push("ar_drop", 4'b0000, 2'd0, 1'b0);
      #1;
      check_pop();
      @(negedge clk);
      reset = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
